rom_port_arbiter: RTL
=====================

ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_DELAY, default 4, meaning cycles from mem_ack match until mem_dout is valid; legal range 1..15.
REQ-002 SHALL have port clk  input  1  system/SDRAM clock, all logic on rising edge.
REQ-003 SHALL have port init_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports cN_req  input  1  toggle request from client N, N=0..2.
REQ-005 SHALL have ports cN_ack  output  1  toggle acknowledge to client N.
REQ-006 SHALL have ports cN_addr  input  23  word address [23:1].
REQ-007 SHALL have ports cN_we  input  1  write when 1, read when 0.
REQ-008 SHALL have ports cN_din  input  16  write data.
REQ-009 SHALL have ports cN_dout  output  16  read data.
REQ-010 SHALL have ports mem_req  output  1  toggle request to the SDRAM ROM port.
REQ-011 SHALL have port mem_ack  input  1  toggle acknowledge from the SDRAM ROM port.
REQ-012 SHALL have ports mem_addr  output  23, mem_we  output  1, mem_din  output  16: registered downstream command.
REQ-013 SHALL have port mem_dout  input  16  downstream read data.
REQ-014 SHALL have port grant  output  2  index of client being served, 3 = none.

Function
REQ-015 SHALL treat client N as pending when cN_req != cN_ack; downstream as complete when mem_req == mem_ack.
REQ-016 SHALL implement states IDLE, WAIT_ACK, WAIT_DATA.
REQ-017 IDLE: if any client pending, SHALL on the same edge select winner, register mem_addr/mem_we/mem_din from it, capture its cN_req value, set grant, toggle mem_req, enter WAIT_ACK; else remain IDLE with grant=3.
REQ-018 WAIT_ACK: on mem_ack == mem_req, write SHALL set winner ack to captured req and return to IDLE in the same edge; read SHALL load delay counter with DATA_DELAY-1 and enter WAIT_DATA.
REQ-019 WAIT_DATA: counter SHALL decrement each cycle; at 0 SHALL register mem_dout into winner cN_dout, set winner ack to captured req on the same edge, return to IDLE.
REQ-020 Client latency SHALL be: toggle seen at edge E, mem_req toggles at E; read ack/dout at (mem_ack match edge)+DATA_DELAY; write ack at match edge.
REQ-021 SHALL keep at most one downstream transaction outstanding.
REQ-022 SHALL NOT change mem_addr/mem_we/mem_din outside the IDLE grant edge.
REQ-023 Write completion SHALL leave cN_dout unchanged; non-winning clients' dout/ack SHALL never change.
REQ-024 Client re-toggling req while in flight SHALL NOT be lost: ack uses captured value, so client remains pending and is served again.
REQ-025 Requests arriving in the completion cycle SHALL be considered at the next IDLE cycle (one idle cycle between transactions minimum).
REQ-026 Clients SHALL hold addr/we/din stable from toggle to ack; arbiter samples only at grant.

Reset
REQ-027 On init_n low, immediately: state IDLE, mem_req=0, cN_ack=0, cN_dout=0, mem_addr=0, mem_we=0, mem_din=0, grant=3, delay counter=0, round-robin pointer=0.
REQ-028 Reset mid-transaction SHALL abandon it silently; downstream controller SHALL share init_n so mem_ack also returns to 0.

Configuration
REQ-029 With ROM_ARB_RR_EN defined SHALL use round-robin: search starts at pointer, pointer <= winner+1 (mod 3) on each grant.
REQ-030 Without ROM_ARB_RR_EN SHALL use fixed priority c0 > c1 > c2; pointer logic absent.

Verification
REQ-031 Single read: c1 toggles, addr=0x000100, mem_ack returns 3 cycles after mem_req, mem_dout=0xBEEF -> mem_addr=0x000100, c1_dout=0xBEEF and c1_ack toggles exactly 4 cycles after mem_ack match.
REQ-032 Single write: c2 we=1, din=0x1234 -> mem_we=1, mem_din=0x1234, c2_ack toggles on match edge, c2_dout stays 0.
REQ-033 All three toggle same cycle, fixed priority -> grant order 0,1,2; with ROM_ARB_RR_EN and pointer=1 -> order 1,2,0.
REQ-034 c0 re-toggles req during WAIT_DATA -> after first ack, c0 still pending and gets a second downstream request.
REQ-035 init_n asserted during WAIT_DATA -> all outputs at reset values asynchronously; after release, a new c0 read completes normally.
REQ-036 DATA_DELAY=1 -> read ack and dout on edge after mem_ack match; no stray extra mem_req toggles.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// ---------------------------------------------------------------------------
// rom_port_arbiter
//
// Shares one toggle-handshake SDRAM ROM port between three toggle-handshake
// clients. A client is pending while its req differs from its ack. The
// arbiter issues one downstream command at a time, waits for the downstream
// ack to match, and either completes a write right away or counts DATA_DELAY
// cycles before capturing mem_dout for a read.
//
// Parameters
//   DATA_DELAY  cycles from the mem_ack match edge until mem_dout is valid
//               (legal range 1..15).
//
// Build option
//   ROM_ARB_RR_EN  when defined, arbitration is round-robin starting at an
//                  internal pointer that moves past each winner. When not
//                  defined, arbitration is fixed priority c0 > c1 > c2.
//
// Ports
//   clk        system / SDRAM clock, rising edge
//   init_n     asynchronous active-low reset
//   cN_req     toggle request from client N (N = 0..2)
//   cN_ack     toggle acknowledge to client N
//   cN_addr    word address [23:1] of client N
//   cN_we      1 = write, 0 = read
//   cN_din     write data from client N
//   cN_dout    read data to client N
//   mem_req    toggle request to the ROM port
//   mem_ack    toggle acknowledge from the ROM port
//   mem_addr   registered downstream address
//   mem_we     registered downstream write enable
//   mem_din    registered downstream write data
//   mem_dout   downstream read data
//   grant      index of the client being served, 3 = none
// ---------------------------------------------------------------------------
module rom_port_arbiter #(
  parameter int DATA_DELAY = 4
) (
  input  logic        clk,
  input  logic        init_n,

  input  logic        c0_req,
  output logic        c0_ack,
  input  logic [22:0] c0_addr,
  input  logic        c0_we,
  input  logic [15:0] c0_din,
  output logic [15:0] c0_dout,

  input  logic        c1_req,
  output logic        c1_ack,
  input  logic [22:0] c1_addr,
  input  logic        c1_we,
  input  logic [15:0] c1_din,
  output logic [15:0] c1_dout,

  input  logic        c2_req,
  output logic        c2_ack,
  input  logic [22:0] c2_addr,
  input  logic        c2_we,
  input  logic [15:0] c2_din,
  output logic [15:0] c2_dout,

  output logic        mem_req,
  input  logic        mem_ack,
  output logic [22:0] mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout,

  output logic [1:0]  grant
);

  localparam logic [1:0] NO_GRANT  = 2'd3;
  localparam logic [3:0] DELAY_RLD = 4'(DATA_DELAY - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Client buses gathered into vectors indexed by client number.
  logic [2:0]       req_vec;
  logic [2:0][22:0] addr_vec;
  logic [2:0]       we_vec;
  logic [2:0][15:0] din_vec;

  logic [2:0]       ack_q, ack_nxt;
  logic [2:0][15:0] dout_q, dout_nxt;
  logic [2:0]       pending;
  logic             mem_done;

  logic [1:0]       win;
  logic             win_vld;

  // Request level of the winner at grant time; the ack is set to this value
  // so that a client re-toggling while in flight stays pending.
  logic             cap_req, cap_req_nxt;
  logic [3:0]       cnt, cnt_nxt;

  logic             mem_req_nxt;
  logic [22:0]      mem_addr_nxt;
  logic             mem_we_nxt;
  logic [15:0]      mem_din_nxt;
  logic [1:0]       grant_nxt;

  assign req_vec  = {c2_req, c1_req, c0_req};
  assign addr_vec = {c2_addr, c1_addr, c0_addr};
  assign we_vec   = {c2_we, c1_we, c0_we};
  assign din_vec  = {c2_din, c1_din, c0_din};

  assign pending  = req_vec ^ ack_q;
  assign mem_done = (mem_req == mem_ack);
  assign win_vld  = |pending;

  assign c0_ack  = ack_q[0];
  assign c1_ack  = ack_q[1];
  assign c2_ack  = ack_q[2];
  assign c0_dout = dout_q[0];
  assign c1_dout = dout_q[1];
  assign c2_dout = dout_q[2];

`ifdef ROM_ARB_RR_EN
  logic [1:0] ptr, ptr_nxt;
  logic [1:0] idx;

  function automatic logic [1:0] add_mod3(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // Scan from the farthest candidate back to the pointer so the last match,
  // i.e. the first pending client at or after the pointer, wins.
  always_comb begin
    win = 2'd0;
    idx = ptr;
    for (int k = 2; k >= 0; k--) begin
      idx = add_mod3(ptr, 2'(k));
      if (pending[idx]) win = idx;
    end
  end

  assign ptr_nxt = (state == IDLE && win_vld) ? add_mod3(win, 2'd1) : ptr;

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) ptr <= 2'd0;
    else         ptr <= ptr_nxt;
  end
`else
  always_comb begin
    if (pending[0])      win = 2'd0;
    else if (pending[1]) win = 2'd1;
    else                 win = 2'd2;
  end
`endif

  always_comb begin
    state_nxt    = state;
    mem_req_nxt  = mem_req;
    mem_addr_nxt = mem_addr;
    mem_we_nxt   = mem_we;
    mem_din_nxt  = mem_din;
    grant_nxt    = grant;
    cap_req_nxt  = cap_req;
    cnt_nxt      = cnt;
    ack_nxt      = ack_q;
    dout_nxt     = dout_q;

    case (state)
      IDLE: begin
        grant_nxt = NO_GRANT;
        if (win_vld) begin
          mem_addr_nxt = addr_vec[win];
          mem_we_nxt   = we_vec[win];
          mem_din_nxt  = din_vec[win];
          cap_req_nxt  = req_vec[win];
          grant_nxt    = win;
          mem_req_nxt  = ~mem_req;
          state_nxt    = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        if (mem_done) begin
          // mem_we still holds the issued command, so it tells read from write.
          if (mem_we) begin
            ack_nxt[grant] = cap_req;
            grant_nxt      = NO_GRANT;
            state_nxt      = IDLE;
          end else begin
            cnt_nxt   = DELAY_RLD;
            state_nxt = WAIT_DATA;
          end
        end
      end

      WAIT_DATA: begin
        if (cnt == 4'd0) begin
          dout_nxt[grant] = mem_dout;
          ack_nxt[grant]  = cap_req;
          grant_nxt       = NO_GRANT;
          state_nxt       = IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end

      default: begin
        grant_nxt = NO_GRANT;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      mem_we   <= 1'b0;
      mem_din  <= '0;
      grant    <= NO_GRANT;
      cap_req  <= 1'b0;
      cnt      <= '0;
      ack_q    <= '0;
      dout_q   <= '0;
    end else begin
      state    <= state_nxt;
      mem_req  <= mem_req_nxt;
      mem_addr <= mem_addr_nxt;
      mem_we   <= mem_we_nxt;
      mem_din  <= mem_din_nxt;
      grant    <= grant_nxt;
      cap_req  <= cap_req_nxt;
      cnt      <= cnt_nxt;
      ack_q    <= ack_nxt;
      dout_q   <= dout_nxt;
    end
  end

endmodule
